muldiv_unit: RTL and testbench
==============================

// Module: muldiv_unit
// PURPOSE
//  Multi-cycle RV32M execute unit. Consumes instructions the decoder flags as
//  is_multiclock: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
//  Sits beside the single-cycle ALU and stalls the pipeline while busy.
//  Uses a radix-2 iterative datapath with a fixed latency.
// PARAMETERS
//  XLEN        32   operand/result width; iteration count = XLEN
// PORTS
//  clk         in   1     single clock, rising edge
//  rst         in   1     synchronous reset, active-high
//  start       in   1     launch op; sampled only in IDLE or DONE
//  cancel      in   1     synchronous abort (pipeline flush)
//  alucode     in   6     ALU_MUL..ALU_REMU from shared ALU code defines
//  op1         in   XLEN  rs1 value (multiplicand / dividend)
//  op2         in   XLEN  rs2 value (multiplier / divisor)
//  busy        out  1     high in CALC and FIX
//  done        out  1     one-cycle pulse; result valid this cycle
//  result      out  XLEN  held from done until next accepted start
// BEHAVIOUR
//  - Reset: state=IDLE, busy=0, done=0, result=0, all internal registers 0.
//  - States and transitions:
//    - IDLE -> CALC on start with an M-extension alucode.
//    - CALC runs XLEN cycles; a counter counts 0..XLEN-1.
//    - CALC -> FIX when the counter reaches XLEN-1.
//    - FIX -> DONE.
//    - DONE -> CALC on a valid start, otherwise DONE -> IDLE.
//  - Latency: start accepted in cycle T gives done=1 and result valid in
//    cycle T+XLEN+2 (34 for XLEN=32). Latency is fixed for every operand,
//    including the special cases.
//  - Accept: on acceptance, latch alucode, op1 and op2, and the sign flags.
//    A start with a non-M alucode is ignored (no state change, no done).
//    start while busy is ignored.
//  - cancel has priority over start. In any state it forces IDLE with
//    busy=0 and done=0 next cycle, and result is unchanged.
//    cancel in the same cycle as start leaves the unit in IDLE.
//  - Operand signedness:
//    - Signed operands: MUL, MULH and DIV/REM use both; MULHSU uses op1 only.
//    - Unsigned operands: MULHU, DIVU and REMU use both; MULHSU uses op2.
//    - The core operates on magnitudes; FIX applies two's-complement
//      negation.
//  - MUL*: shift-add into a 2*XLEN accumulator.
//    - MUL returns product[XLEN-1:0].
//    - MULH, MULHSU and MULHU return product[2XLEN-1:XLEN].
//    - The product is negated when the operand signs differ.
//  - DIV*: restoring shift-subtract producing quotient q and remainder r.
//    - q sign = s1^s2; r sign = sign of dividend.
//  - Divide by zero: q = all ones; r = op1 (unchanged dividend).
//  - Signed overflow (op1=0x80000000, op2=-1, DIV/REM): q = 0x80000000, r = 0.
//  - Special cases are detected at accept and applied in FIX.
//    No early termination.
//  - rst mid-operation behaves exactly as reset: no done, result=0.
// STRUCTURE
//  - ALU_MUL..ALU_REMU codes come from the existing shared ALU/OP define
//    header. Do not redefine them locally.
//  - The state encoding (IDLE/CALC/FIX/DONE) is localparam and private to
//    this block.
//  - Single module with no sub-modules. The mul and div iterations share
//    the 2*XLEN shift register and the counter.
// TESTING
//  1. MUL 7 x -3 -> done at T+34, result=0xFFFFFFEB; MULHU 0xFFFFFFFF x
//     0xFFFFFFFF -> 0xFFFFFFFE.
//  2. MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHSU -1 x 0xFFFFFFFF
//     -> 0xFFFFFFFF.
//  3. DIV -7/2 -> 0xFFFFFFFD, REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14,
//     REMU -> 2.
//  4. DIV 5/0 -> 0xFFFFFFFF, REMU 5/0 -> 5; DIV 0x80000000/-1 -> 0x80000000,
//     REM -> 0; all still at T+34.
//  5. start in the DONE cycle -> back-to-back op, next done at +34. start
//     while busy -> ignored. Non-M alucode start -> no busy.
//  6. cancel at CALC cycle 10 -> IDLE next cycle, no done, result holds the
//     prior value. rst mid-CALC -> busy=0, done=0, result=0.

Source files
------------

// File: rtl/muldiv_unit_pkg.sv
// Shared RV32M ALU operation codes and helpers for the multi-cycle execute unit.
package muldiv_unit_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned ALU_W = 6;

  localparam logic [ALU_W-1:0] ALU_MUL    = 6'h20;
  localparam logic [ALU_W-1:0] ALU_MULH   = 6'h21;
  localparam logic [ALU_W-1:0] ALU_MULHSU = 6'h22;
  localparam logic [ALU_W-1:0] ALU_MULHU  = 6'h23;
  localparam logic [ALU_W-1:0] ALU_DIV    = 6'h24;
  localparam logic [ALU_W-1:0] ALU_DIVU   = 6'h25;
  localparam logic [ALU_W-1:0] ALU_REM    = 6'h26;
  localparam logic [ALU_W-1:0] ALU_REMU   = 6'h27;

  function automatic logic is_m_op(input logic [ALU_W-1:0] code);
    return code inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
                        ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
  endfunction

  function automatic logic is_div_op(input logic [ALU_W-1:0] code);
    return code inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Multi-cycle RV32M multiply/divide unit: radix-2 shift-add / restoring divide,
// fixed XLEN+2 cycle latency, shared 2*XLEN shift register and counter.
module muldiv_unit
  import muldiv_unit_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cancel,
  input  logic [ALU_W-1:0] alucode,
  input  logic [XLEN-1:0]  op1,
  input  logic [XLEN-1:0]  op2,
  output logic             busy,
  output logic             done,
  output logic [XLEN-1:0]  result
);

  localparam int unsigned CNT_W = $clog2(XLEN);
  localparam int unsigned AW    = 2 * XLEN;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [AW-1:0]    r_acc;
  logic [XLEN-1:0]  r_b;
  logic [XLEN-1:0]  r_op1;
  logic [ALU_W-1:0] r_code;
  logic             r_s1;
  logic             r_s2;
  logic             r_div0;
  logic             r_ovf;

  logic [1:0]       w_state_nxt;
  logic             w_accept;
  logic             w_is_m;
  logic             w_is_div;
  logic             w_s1;
  logic             w_s2;
  logic [XLEN-1:0]  w_mag1;
  logic [XLEN-1:0]  w_mag2;
  logic [XLEN:0]    w_mul_sum;
  logic [AW-1:0]    w_mul_next;
  logic [XLEN:0]    w_div_diff;
  logic [AW-1:0]    w_div_next;
  logic [AW-1:0]    w_prod;
  logic [XLEN-1:0]  w_quo;
  logic [XLEN-1:0]  w_rem;
  logic [XLEN-1:0]  w_fix;

  // Operand decode at accept: effective signs and magnitudes
  always_comb begin
    w_is_m   = is_m_op(alucode);
    w_is_div = is_div_op(alucode);
    w_s1     = op1[XLEN-1] &&
               (alucode inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_DIV, ALU_REM});
    w_s2     = op2[XLEN-1] &&
               (alucode inside {ALU_MUL, ALU_MULH, ALU_DIV, ALU_REM});
    w_mag1   = w_s1 ? -op1 : op1;
    w_mag2   = w_s2 ? -op2 : op2;
  end

  // Next-state logic; cancel overrides any launch
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: if (start && w_is_m) begin
        w_state_nxt = S_CALC;
        w_accept    = 1'b1;
      end
      S_CALC: if (r_cnt == CNT_W'(XLEN-1)) w_state_nxt = S_FIX;
      S_FIX:  w_state_nxt = S_DONE;
      S_DONE: if (start && w_is_m) begin
        w_state_nxt = S_CALC;
        w_accept    = 1'b1;
      end else begin
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (cancel) begin
      w_state_nxt = S_IDLE;
      w_accept    = 1'b0;
    end
  end

  // One iteration step: upper half is accumulator / partial remainder
  always_comb begin
    w_mul_sum  = {1'b0, r_acc[AW-1:XLEN]} + {1'b0, r_b};
    w_mul_next = r_acc[0] ? {w_mul_sum, r_acc[XLEN-1:1]} : {1'b0, r_acc[AW-1:1]};
    w_div_diff = r_acc[AW-1:XLEN-1] - {1'b0, r_b};
    w_div_next = w_div_diff[XLEN] ? {r_acc[AW-2:0], 1'b0}
                                  : {w_div_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
  end

  // Sign fix-up and special-case override applied in FIX
  always_comb begin
    w_prod = (r_s1 ^ r_s2) ? -r_acc : r_acc;
    w_quo  = (r_s1 ^ r_s2) ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
    w_rem  = r_s1 ? -r_acc[AW-1:XLEN] : r_acc[AW-1:XLEN];
    w_fix  = '0;
    case (r_code)
      ALU_MUL:                        w_fix = w_prod[XLEN-1:0];
      ALU_MULH, ALU_MULHSU, ALU_MULHU: w_fix = w_prod[AW-1:XLEN];
      ALU_DIV, ALU_DIVU:
        if (r_div0)     w_fix = '1;
        else if (r_ovf) w_fix = {1'b1, (XLEN-1)'(0)};
        else            w_fix = w_quo;
      ALU_REM, ALU_REMU:
        if (r_div0)     w_fix = r_op1;
        else if (r_ovf) w_fix = '0;
        else            w_fix = w_rem;
      default:          w_fix = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_b     <= '0;
      r_op1   <= '0;
      r_code  <= '0;
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_div0  <= 1'b0;
      r_ovf   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
    end else begin
      r_state <= w_state_nxt;
      busy    <= (w_state_nxt == S_CALC) || (w_state_nxt == S_FIX);
      done    <= (w_state_nxt == S_DONE);
      if (w_accept) begin
        r_code <= alucode;
        r_op1  <= op1;
        r_s1   <= w_s1;
        r_s2   <= w_s2;
        r_div0 <= w_is_div && (op2 == '0);
        r_ovf  <= (alucode inside {ALU_DIV, ALU_REM}) &&
                  (op1 == {1'b1, (XLEN-1)'(0)}) && (op2 == '1);
        r_cnt  <= '0;
        r_acc  <= w_is_div ? {XLEN'(0), w_mag1} : {XLEN'(0), w_mag2};
        r_b    <= w_is_div ? w_mag2 : w_mag1;
      end else if (r_state == S_CALC) begin
        r_acc <= is_div_op(r_code) ? w_div_next : w_mul_next;
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if ((r_state == S_FIX) && !cancel) result <= w_fix;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: scoreboard of expected results, fixed
// latency checks, special cases, back-to-back, ignore, cancel and reset.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        cancel;
  logic [5:0]  alucode;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] sb_q[$];
  logic [31:0] last_res = 32'h0;

  muldiv_unit dut (
    .clk(clk), .rst(rst), .start(start), .cancel(cancel), .alucode(alucode),
    .op1(op1), .op2(op2), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [31:0] model(input logic [5:0] c, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] sa, sb, ua, ub, p;
    logic [31:0] r;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'h0, a};
    ub = {32'h0, b};
    r  = 32'h0;
    case (c)
      ALU_MUL:    begin p = sa * sb; r = p[31:0];  end
      ALU_MULH:   begin p = sa * sb; r = p[63:32]; end
      ALU_MULHSU: begin p = sa * ub; r = p[63:32]; end
      ALU_MULHU:  begin p = ua * ub; r = p[63:32]; end
      ALU_DIV:
        if (b == 32'h0) r = 32'hFFFFFFFF;
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = 32'h80000000;
        else r = 32'($signed(a) / $signed(b));
      ALU_REM:
        if (b == 32'h0) r = a;
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = 32'h0;
        else r = 32'($signed(a) % $signed(b));
      ALU_DIVU: r = (b == 32'h0) ? 32'hFFFFFFFF : a / b;
      ALU_REMU: r = (b == 32'h0) ? a : a % b;
      default:  r = 32'h0;
    endcase
    return r;
  endfunction

  // Called at a negedge; start is sampled on the following posedge
  task automatic launch(input logic [5:0] c, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] e);
    alucode = c;
    op1     = a;
    op2     = b;
    start   = 1'b1;
    sb_q.push_back(e);
    @(negedge clk);
    start   = 1'b0;
    op1     = $urandom;
    op2     = $urandom;
  endtask

  // n0 = cycles already elapsed since acceptance (1 right after launch)
  task automatic wait_done(input string name, input int n0);
    int n;
    logic [31:0] e;
    n = n0;
    while (done !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    e = sb_q.pop_front();
    n_checks++;
    if (done !== 1'b1) begin
      $display("FAIL %s timeout: done not seen after %0d cycles", name, n);
      return;
    end
    n_pass++;
    n_checks++;
    if (n !== 34) $display("FAIL %s latency: got %0d required 34", name, n);
    else n_pass++;
    n_checks++;
    if (result !== e) $display("FAIL %s result: got %08h required %08h", name, result, e);
    else n_pass++;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL %s busy_at_done: got %b required 0", name, busy);
    else n_pass++;
    last_res = e;
  endtask

  task automatic run_op(input logic [5:0] c, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] e, input string name);
    @(negedge clk);
    launch(c, a, b, e);
    wait_done(name, 1);
  endtask

  // Watch for a stray done over a window of cycles
  task automatic expect_quiet(input string name, input int cycles);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
    end
    n_checks++;
    if (seen) $display("FAIL %s: got done/busy activity required none", name);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; cancel = 1'b0; alucode = 6'h0; op1 = 32'h0; op2 = 32'h0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) $display("FAIL reset_busy: got %b required 0", busy); else n_pass++;
    n_checks++;
    if (done !== 1'b0) $display("FAIL reset_done: got %b required 0", done); else n_pass++;
    n_checks++;
    if (result !== 32'h0) $display("FAIL reset_result: got %08h required 0", result);
    else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_mul();
    run_op(ALU_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, "mul_7x-3");
    run_op(ALU_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, "mulhu_max");
    run_op(ALU_MULH,   32'h80000000, 32'h80000000, 32'h40000000, "mulh_min");
    run_op(ALU_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, "mulhsu_neg");
  endtask

  task automatic test_div();
    run_op(ALU_DIV,  32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, "div_-7/2");
    run_op(ALU_REM,  32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, "rem_-7/2");
    run_op(ALU_DIVU, 32'd100,      32'd7, 32'd14,       "divu_100/7");
    run_op(ALU_REMU, 32'd100,      32'd7, 32'd2,        "remu_100/7");
  endtask

  task automatic test_special();
    run_op(ALU_DIV,  32'd5,        32'd0,        32'hFFFFFFFF, "div_by0");
    run_op(ALU_REMU, 32'd5,        32'd0,        32'd5,        "remu_by0");
    run_op(ALU_REM,  32'hFFFFFFF7, 32'd0,        32'hFFFFFFF7, "rem_neg_by0");
    run_op(ALU_DIVU, 32'h12345678, 32'd0,        32'hFFFFFFFF, "divu_by0");
    run_op(ALU_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, "div_ovf");
    run_op(ALU_REM,  32'h80000000, 32'hFFFFFFFF, 32'h0,        "rem_ovf");
  endtask

  task automatic test_random();
    logic [5:0]  c;
    logic [31:0] a, b;
    for (int i = 0; i < 12; i++) begin
      c = ALU_MUL + 6'($urandom_range(0, 7));
      a = $urandom;
      b = (i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
      if (i % 4 == 1) a = -a;
      run_op(c, a, b, model(c, a, b), "random");
    end
  endtask

  task automatic test_back_to_back();
    run_op(ALU_MULHU, 32'hDEADBEEF, 32'h01234567, model(ALU_MULHU, 32'hDEADBEEF, 32'h01234567),
           "b2b_first");
    launch(ALU_DIV, 32'hFFFF0000, 32'd3, model(ALU_DIV, 32'hFFFF0000, 32'd3));
    wait_done("b2b_second", 1);
    launch(ALU_REMU, 32'd1000, 32'd33, 32'd10);
    wait_done("b2b_third", 1);
  endtask

  task automatic test_ignore();
    @(negedge clk);
    launch(ALU_MUL, 32'd6, 32'd7, 32'd42);
    repeat (9) @(negedge clk);
    n_checks++;
    if (busy !== 1'b1) $display("FAIL busy_mid_calc: got %b required 1", busy); else n_pass++;
    alucode = ALU_DIVU; op1 = 32'd99; op2 = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("start_while_busy", 11);
    @(negedge clk);
    alucode = 6'h01; op1 = 32'd1; op2 = 32'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL non_m_busy: got %b required 0", busy); else n_pass++;
    expect_quiet("non_m_quiet", 40);
  endtask

  task automatic test_cancel();
    logic [31:0] dropped;
    @(negedge clk);
    launch(ALU_MUL, 32'd123, 32'd456, 32'd56088);
    repeat (10) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    dropped = sb_q.pop_front();
    n_checks++;
    if (busy !== 1'b0) $display("FAIL cancel_busy: got %b required 0", busy); else n_pass++;
    n_checks++;
    if (result !== last_res)
      $display("FAIL cancel_result: got %08h required %08h (dropped %08h)", result, last_res, dropped);
    else n_pass++;
    expect_quiet("cancel_quiet", 40);
    alucode = ALU_DIV; op1 = 32'd50; op2 = 32'd5; start = 1'b1; cancel = 1'b1;
    @(negedge clk);
    start = 1'b0; cancel = 1'b0;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL cancel_with_start: got busy %b required 0", busy);
    else n_pass++;
    expect_quiet("cancel_start_quiet", 40);
    n_checks++;
    if (result !== last_res) $display("FAIL cancel_hold: got %08h required %08h", result, last_res);
    else n_pass++;
    run_op(ALU_DIVU, 32'd81, 32'd9, 32'd9, "after_cancel");
  endtask

  task automatic test_rst_mid();
    logic [31:0] dropped;
    @(negedge clk);
    launch(ALU_REM, 32'hFFFFFF00, 32'd7, model(ALU_REM, 32'hFFFFFF00, 32'd7));
    repeat (15) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    dropped = sb_q.pop_front();
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0)
      $display("FAIL rst_mid_ctrl: got busy %b done %b required 0 0", busy, done);
    else n_pass++;
    n_checks++;
    if (result !== 32'h0) $display("FAIL rst_mid_result: got %08h required 0 (dropped %08h)",
                                   result, dropped);
    else n_pass++;
    expect_quiet("rst_mid_quiet", 40);
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_random();
    test_back_to_back();
    test_ignore();
    test_cancel();
    test_rst_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
